// File: rtl/rs_issue_scheduler.sv
// Reservation-station issue scheduler for one functional unit. It holds entries in a
// collapsing age-ordered queue, wakes pending operands from two CDBs, and issues the oldest ready entry.
module rs_issue_scheduler #(
    parameter int ENTRIES = 4,
    parameter int OP_W    = 6,
    parameter int CNT_W   = $clog2(ENTRIES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             dispatch_valid,
    output logic             dispatch_ready,
    input  logic [OP_W-1:0]  dispatch_op,
    input  logic [5:0]       dispatch_dest_tag,
    input  logic [32:0]      dispatch_src1,
    input  logic [32:0]      dispatch_src2,
    input  logic [37:0]      cdb1,
    input  logic [37:0]      cdb2,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [OP_W-1:0]  issue_op,
    output logic [5:0]       issue_dest_tag,
    output logic [31:0]      issue_data1,
    output logic [31:0]      issue_data2,
    output logic [CNT_W-1:0] count
);
    localparam int IDX_W = $clog2(ENTRIES);

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [5:0]      dest;
        logic [32:0]     src1;
        logic [32:0]     src2;
    } entry_t;

    entry_t             slots     [ENTRIES];
    entry_t             woken     [ENTRIES];
    entry_t             slots_nxt [ENTRIES];
    logic [ENTRIES-1:0] ready;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   lock_idx;
    logic               lock_valid;
    logic               any_ready;
    logic               disp_fire;
    logic               issue_fire;
    logic [CNT_W-1:0]   count_nxt;

    // Ready operands pass through untouched; tag 0 is the idle bus encoding and never matches.
    function automatic logic [32:0] wake(input logic [32:0] s, input logic [37:0] c1,
                                         input logic [37:0] c2);
        if (s[32] || s[5:0] == 6'd0) return s;
        if (s[5:0] == c1[37:32])     return {1'b1, c1[31:0]};
        if (s[5:0] == c2[37:32])     return {1'b1, c2[31:0]};
        return s;
    endfunction

    // Selection. A presented-but-unaccepted entry stays locked, so an older slot that
    // becomes ready cannot change the outputs in the middle of a handshake.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        any_ready = 1'b0;
        sel_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            ready[i] = (CNT_W'(i) < count) && slots[i].src1[32] && slots[i].src2[32];
            if (ready[i]) begin
                any_ready = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
        pick        = lock_valid ? lock_idx : sel_idx;
        issue_valid = lock_valid || any_ready;
    end

    assign issue_op       = issue_valid ? slots[pick].op         : '0;
    assign issue_dest_tag = issue_valid ? slots[pick].dest       : '0;
    assign issue_data1    = issue_valid ? slots[pick].src1[31:0] : '0;
    assign issue_data2    = issue_valid ? slots[pick].src2[31:0] : '0;

    assign dispatch_ready = (count < CNT_W'(ENTRIES));
    assign disp_fire      = dispatch_valid && dispatch_ready && !flush;
    assign issue_fire     = issue_valid && issue_ready && !flush;
    assign wr_idx         = IDX_W'(issue_fire ? count - CNT_W'(1) : count);

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            woken[i]      = slots[i];
            woken[i].src1 = wake(slots[i].src1, cdb1, cdb2);
            woken[i].src2 = wake(slots[i].src2, cdb1, cdb2);
            slots_nxt[i]  = woken[i];
        end
        // Collapse: younger slots shift down and keep any capture made this cycle.
        if (issue_fire) begin
            for (int i = 0; i < ENTRIES - 1; i++) begin
                if (IDX_W'(i) >= pick) slots_nxt[i] = woken[i + 1];
            end
        end
        if (disp_fire) begin
            slots_nxt[wr_idx].op   = dispatch_op;
            slots_nxt[wr_idx].dest = dispatch_dest_tag;
            slots_nxt[wr_idx].src1 = wake(dispatch_src1, cdb1, cdb2);
            slots_nxt[wr_idx].src2 = wake(dispatch_src2, cdb1, cdb2);
        end
        case ({disp_fire, issue_fire})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst || flush) begin
            count      <= '0;
            lock_valid <= 1'b0;
            lock_idx   <= '0;
        end else begin
            count      <= count_nxt;
            lock_valid <= issue_valid && !issue_ready;
            lock_idx   <= pick;
        end
    end

    // NOTE: slot payload is not reset; occupancy comes only from count, and outputs are gated by issue_valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) slots[i] <= slots_nxt[i];
    end
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Self-checking bench for rs_issue_scheduler: expected issue packets are queued as stimulus
// makes them inevitable and compared against each accepted issue.
module tb_rs_issue_scheduler;
    localparam int ENTRIES = 4;
    localparam int OP_W    = 6;
    localparam int CNT_W   = $clog2(ENTRIES + 1);

    logic             clk = 1'b0;
    logic             rst, flush, dispatch_valid, dispatch_ready, issue_valid, issue_ready;
    logic [OP_W-1:0]  dispatch_op, issue_op;
    logic [5:0]       dispatch_dest_tag, issue_dest_tag;
    logic [32:0]      dispatch_src1, dispatch_src2;
    logic [37:0]      cdb1, cdb2;
    logic [31:0]      issue_data1, issue_data2;
    logic [CNT_W-1:0] count;

    typedef logic [OP_W+6+64-1:0] pkt_t;
    pkt_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    rs_issue_scheduler #(.ENTRIES(ENTRIES), .OP_W(OP_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_op(dispatch_op), .dispatch_dest_tag(dispatch_dest_tag),
        .dispatch_src1(dispatch_src1), .dispatch_src2(dispatch_src2),
        .cdb1(cdb1), .cdb2(cdb2),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_dest_tag(issue_dest_tag),
        .issue_data1(issue_data1), .issue_data2(issue_data2),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every accepted issue is popped and compared; an issue nobody expected is a failure.
    always @(negedge clk) begin
        if (!rst && !flush && issue_valid && issue_ready) begin
            if (exp_q.size() == 0) check("unexpected_issue", {74'd0, issue_dest_tag}, 80'd0);
            else check("issue_pkt", {issue_op, issue_dest_tag, issue_data1, issue_data2},
                       exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        dispatch_valid = 1'b0;
        flush          = 1'b0;
        cdb1           = '0;
        cdb2           = '0;
    endtask

    task automatic drive_dispatch(input logic [OP_W-1:0] op, input logic [5:0] dest,
                                  input logic [32:0] s1, input logic [32:0] s2);
        dispatch_valid    = 1'b1;
        dispatch_op       = op;
        dispatch_dest_tag = dest;
        dispatch_src1     = s1;
        dispatch_src2     = s2;
    endtask

    task automatic expect_pkt(input logic [OP_W-1:0] op, input logic [5:0] dest,
                              input logic [31:0] d1, input logic [31:0] d2);
        exp_q.push_back({op, dest, d1, d2});
    endtask

    initial begin
        rst = 1'b1;
        issue_ready = 1'b0;
        dispatch_op = '0; dispatch_dest_tag = '0; dispatch_src1 = '0; dispatch_src2 = '0;
        clear_inputs();
        tick(); tick();
        rst = 1'b0;
        check("rst_count", 80'(count), 80'd0);
        check("rst_issue_valid", 80'(issue_valid), 80'd0);
        check("rst_dispatch_ready", 80'(dispatch_ready), 80'd1);
        check("rst_issue_data1", 80'(issue_data1), 80'd0);

        // Both operands ready at dispatch: issue one cycle later.
        drive_dispatch(6'd3, 6'd5, {1'b1, 32'h10}, {1'b1, 32'h20});
        expect_pkt(6'd3, 6'd5, 32'h10, 32'h20);
        issue_ready = 1'b1;
        tick(); clear_inputs();
        check("t1_issue_valid", 80'(issue_valid), 80'd1);
        check("t1_dest", 80'(issue_dest_tag), 80'd5);
        tick();
        check("t1_count_after", 80'(count), 80'd0);

        // Pending src1 woken by cdb2.
        drive_dispatch(6'd1, 6'd10, {1'b0, 32'd9}, {1'b1, 32'h22});
        tick(); clear_inputs();
        check("t2_wait_valid", 80'(issue_valid), 80'd0);
        check("t2_count", 80'(count), 80'd1);
        tick();
        check("t2_still_wait", 80'(issue_valid), 80'd0);
        cdb2 = {6'd9, 32'hAB};
        expect_pkt(6'd1, 6'd10, 32'hAB, 32'h22);
        tick(); clear_inputs();
        check("t2_woken_valid", 80'(issue_valid), 80'd1);
        check("t2_data1", 80'(issue_data1), 80'hAB);
        tick();

        // Both CDBs hit the same tag: cdb1 wins.
        drive_dispatch(6'd2, 6'd11, {1'b0, 32'd9}, {1'b1, 32'h22});
        tick(); clear_inputs();
        cdb1 = {6'd9, 32'hC1};
        cdb2 = {6'd9, 32'hC2};
        expect_pkt(6'd2, 6'd11, 32'hC1, 32'h22);
        tick(); clear_inputs();
        check("t2b_data1_cdb1", 80'(issue_data1), 80'hC1);
        tick();

        // Capture on the dispatch cycle itself.
        drive_dispatch(6'd4, 6'd12, {1'b1, 32'h1}, {1'b0, 32'd7});
        cdb1 = {6'd7, 32'h55};
        expect_pkt(6'd4, 6'd12, 32'h1, 32'h55);
        tick(); clear_inputs();
        check("t3_valid", 80'(issue_valid), 80'd1);
        check("t3_data2", 80'(issue_data2), 80'h55);
        tick();
        check("t3_count", 80'(count), 80'd0);

        // Fill with pending entries dest 20..23 (src1 tags 30..33).
        for (int i = 0; i < ENTRIES; i++) begin
            drive_dispatch(6'(i), 6'(20 + i), {1'b0, 32'(30 + i)}, {1'b1, 32'(256 + i)});
            tick();
        end
        clear_inputs();
        check("fill_count", 80'(count), 80'd4);
        check("fill_dispatch_ready", 80'(dispatch_ready), 80'd0);
        check("fill_issue_valid", 80'(issue_valid), 80'd0);
        cdb1 = {6'd32, 32'hA2};
        cdb2 = {6'd31, 32'hA1};
        expect_pkt(6'd1, 6'd21, 32'hA1, 32'd257);
        expect_pkt(6'd2, 6'd22, 32'hA2, 32'd258);
        tick(); clear_inputs();
        check("wake2_first_dest", 80'(issue_dest_tag), 80'd21);
        check("wake2_count4", 80'(count), 80'd4);
        tick();
        check("wake2_count3", 80'(count), 80'd3);
        check("wake2_second_dest", 80'(issue_dest_tag), 80'd22);
        tick();
        check("wake2_count2", 80'(count), 80'd2);
        check("wake2_idle", 80'(issue_valid), 80'd0);

        // Handshake lock: slot 2 presented and held while slot 0 wakes.
        issue_ready = 1'b0;
        drive_dispatch(6'd5, 6'd24, {1'b0, 32'd34}, {1'b1, 32'h300});
        tick(); clear_inputs();
        check("lock_count3", 80'(count), 80'd3);
        cdb1 = {6'd34, 32'hA4};
        expect_pkt(6'd5, 6'd24, 32'hA4, 32'h300);
        tick(); clear_inputs();
        check("lock_presented", 80'(issue_dest_tag), 80'd24);
        cdb1 = {6'd30, 32'hA0};
        expect_pkt(6'd0, 6'd20, 32'hA0, 32'd256);
        tick(); clear_inputs();
        check("lock_hold_dest", 80'(issue_dest_tag), 80'd24);
        check("lock_hold_data1", 80'(issue_data1), 80'hA4);
        tick();
        check("lock_hold_dest2", 80'(issue_dest_tag), 80'd24);
        issue_ready = 1'b1;
        tick();
        check("lock_next_dest", 80'(issue_dest_tag), 80'd20);
        check("lock_count2", 80'(count), 80'd2);
        tick();
        check("lock_count1", 80'(count), 80'd1);
        check("lock_remaining_wait", 80'(issue_valid), 80'd0);

        // Flush with 3 valid entries and a simultaneous dispatch.
        drive_dispatch(6'd6, 6'd25, {1'b0, 32'd35}, {1'b1, 32'h0});
        tick();
        drive_dispatch(6'd7, 6'd26, {1'b0, 32'd36}, {1'b1, 32'h0});
        tick();
        check("pre_flush_count", 80'(count), 80'd3);
        drive_dispatch(6'd8, 6'd27, {1'b1, 32'h77}, {1'b1, 32'h88});
        flush = 1'b1;
        tick(); clear_inputs();
        check("flush_count", 80'(count), 80'd0);
        check("flush_issue_valid", 80'(issue_valid), 80'd0);
        check("flush_dispatch_ready", 80'(dispatch_ready), 80'd1);
        check("flush_data1", 80'(issue_data1), 80'd0);
        cdb1 = {6'd33, 32'hDD};
        tick(); clear_inputs();
        tick();
        check("post_flush_idle", 80'(issue_valid), 80'd0);
        check("scoreboard_empty", 80'(exp_q.size()), 80'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
